// File: rtl/router_fifo.sv
// router_fifo -- per-destination packet FIFO of the 1x3 router.
//
// Stores packet bytes together with a header tag bit. It also tracks how many
// bytes of the packet currently being drained are still to be read.
//
// Ports
//   clock       : single clock, all state updates on posedge
//   resetn      : synchronous reset, active-low (highest priority)
//   soft_reset  : synchronous flush from the synchronizer timeout, active-high
//   write_enb   : write request (ignored while full)
//   read_enb    : read request (ignored while empty)
//   lfd_state   : byte on data_in this cycle is a packet header
//   data_in     : byte to store
//   data_out    : registered read data, holds when no read is accepted
//   full        : occupancy == DEPTH, decoded from the pointers only
//   empty       : occupancy == 0, decoded from the pointers only
module router_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Storage word: bit WIDTH is the header tag, the rest is the byte.
   logic [WIDTH:0]   mem_q [DEPTH];

   // Pointers carry one extra bit so that full and empty can be told apart.
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [5:0]       pkt_cnt_q, pkt_cnt_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;

   logic             wr_acc;
   logic             rd_acc;
   logic             mem_we;
   logic [WIDTH:0]   rd_word;

   assign empty    = (wptr_q == rptr_q);
   assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign data_out = data_out_q;

   assign wr_acc  = write_enb && !full;
   assign rd_acc  = read_enb && !empty;
   assign rd_word = mem_q[rptr_q[AW-1:0]];

   // A flush or reset discards any write in the same cycle.
   assign mem_we  = wr_acc && resetn && !soft_reset;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      pkt_cnt_d  = pkt_cnt_q;
      data_out_d = data_out_q;

      if (soft_reset) begin
         wptr_d     = '0;
         rptr_d     = '0;
         pkt_cnt_d  = '0;
         data_out_d = '0;
      end else begin
         if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
         end
         if (rd_acc) begin
            rptr_d     = rptr_q + 1'b1;
            data_out_d = rd_word[WIDTH-1:0];
            // A header loads the payload length plus one for the parity byte.
            if (rd_word[WIDTH]) begin
               pkt_cnt_d = rd_word[7:2] + 6'd1;
            end else if (pkt_cnt_q != 6'd0) begin
               pkt_cnt_d = pkt_cnt_q - 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         data_out_q <= data_out_d;
      end
   end

   // Memory has no reset; its contents after a flush are don't-care.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[wptr_q[AW-1:0]] <= {lfd_state, data_in};
      end
   end

endmodule
